// File: rtl/mood_reporter.sv
// Mood status UART transmitter: samples the core's emotion/status bytes and sends
// a 4-byte 8N1 packet {A5, emotion, status, checksum} on change or on request.
module mood_reporter #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] emotion,
  input  logic [7:0] status,
  input  logic       report_req,
  output logic       tx,
  output logic       busy,
  output logic [7:0] pkt_count
);

  localparam int          CW      = 12;
  localparam logic [7:0]  SYNC_B  = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_GAP
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;

  logic [15:0]     r_s1;
  logic [15:0]     r_s2;
  logic [15:0]     r_last_sent;
  logic [15:0]     r_snap;
  logic            r_warm0;
  logic            r_warm;
  logic            r_pending;
  logic [CW-1:0]   r_clk_cnt;
  logic [2:0]      r_bit_idx;
  logic [1:0]      r_byte_idx;
  logic [7:0]      r_pkt_count;

  logic            w_bit_end;
  logic            w_can_launch;
  logic            w_launch;
  logic            w_last_byte_done;
  logic [7:0]      w_byte;

  // Two-stage capture of the asynchronous core outputs; s1==s2 marks a settled sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1    <= '0;
      r_s2    <= '0;
      r_warm0 <= 1'b0;
      r_warm  <= 1'b0;
    end else begin
      r_s1    <= {emotion, status};
      r_s2    <= r_s1;
      r_warm0 <= 1'b1;
      r_warm  <= r_warm0;
    end
  end

  assign w_bit_end        = (r_clk_cnt == CW'(CLKS_PER_BIT - 1));
  assign w_can_launch     = r_warm && (r_s1 == r_s2) && (r_pending || (r_s2 != r_last_sent));
  assign w_last_byte_done = (r_state == ST_STOP) && w_bit_end && (r_byte_idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // The gap exit re-evaluates the trigger so a queued report starts with no idle cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_can_launch) begin
          w_launch    = 1'b1;
          w_state_nxt = ST_START;
        end
      end
      ST_START: if (w_bit_end) w_state_nxt = ST_DATA;
      ST_DATA:  if (w_bit_end && (r_bit_idx == 3'd7)) w_state_nxt = ST_STOP;
      ST_STOP: begin
        if (w_bit_end) w_state_nxt = (r_byte_idx == 2'd3) ? ST_GAP : ST_START;
      end
      ST_GAP: begin
        if (w_bit_end) begin
          if (w_can_launch) begin
            w_launch    = 1'b1;
            w_state_nxt = ST_START;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_byte_idx  <= '0;
      r_pkt_count <= '0;
      r_pending   <= 1'b1;
      r_snap      <= '0;
      r_last_sent <= '0;
    end else begin
      if ((r_state == ST_IDLE) || w_bit_end) r_clk_cnt <= '0;
      else                                   r_clk_cnt <= r_clk_cnt + CW'(1);

      if (w_launch)                                r_bit_idx <= '0;
      else if ((r_state == ST_DATA) && w_bit_end)  r_bit_idx <= r_bit_idx + 3'd1;

      if (w_launch)
        r_byte_idx <= '0;
      else if ((r_state == ST_STOP) && w_bit_end && (r_byte_idx != 2'd3))
        r_byte_idx <= r_byte_idx + 2'd1;

      if (w_last_byte_done) r_pkt_count <= r_pkt_count + 8'd1;

      // A request landing on the launch edge must survive to force one more packet.
      if (report_req)    r_pending <= 1'b1;
      else if (w_launch) r_pending <= 1'b0;

      if (w_launch) begin
        r_snap      <= r_s2;
        r_last_sent <= r_s2;
      end
    end
  end

  always_comb begin
    w_byte = SYNC_B;
    case (r_byte_idx)
      2'd0:    w_byte = SYNC_B;
      2'd1:    w_byte = r_snap[15:8];
      2'd2:    w_byte = r_snap[7:0];
      default: w_byte = SYNC_B ^ r_snap[15:8] ^ r_snap[7:0];
    endcase
  end

  always_comb begin
    tx = 1'b1;
    case (r_state)
      ST_START: tx = 1'b0;
      ST_DATA:  tx = w_byte[r_bit_idx];
      default:  tx = 1'b1;
    endcase
  end

  assign busy      = (r_state != ST_IDLE);
  assign pkt_count = r_pkt_count;

endmodule

// File: tb/tb_mood_reporter.sv
// Directed bench for mood_reporter: decodes the UART line and checks packet
// contents, launch timing, glitch rejection, coalescing, reset and counter wrap.
module tb_mood_reporter;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] emotion = 8'h00;
  logic [7:0] status = 8'h00;
  logic       report_req = 1'b0;
  logic       tx;
  logic       busy;
  logic [7:0] pkt_count;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int busy_hi = 0;
  int tx_low = 0;

  mood_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .emotion    (emotion),
    .status     (status),
    .report_req (report_req),
    .tx         (tx),
    .busy       (busy),
    .pkt_count  (pkt_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_hi = busy_hi + 1;
    if (tx === 1'b0)   tx_low  = tx_low + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(input int bound, output int edge_n);
    edge_n = -1;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (tx === 1'b0) begin
        edge_n = cyc;
        break;
      end
    end
  endtask

  task automatic recv_byte(input bit first, output logic [7:0] b);
    if (!first) begin
      repeat (CPB) @(negedge clk);
      check("start_bit", tx, 1'b0);
    end
    for (int j = 0; j < 8; j++) begin
      repeat (CPB) @(negedge clk);
      b[j] = tx;
    end
    repeat (CPB) @(negedge clk);
    check("stop_bit", tx, 1'b1);
  endtask

  task automatic recv_pkt(output logic [7:0] b0, output logic [7:0] b1,
                          output logic [7:0] b2, output logic [7:0] b3);
    recv_byte(1'b1, b0);
    recv_byte(1'b0, b1);
    recv_byte(1'b0, b2);
    recv_byte(1'b0, b3);
  endtask

  task automatic check_pkt(input string tag, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3,
                           input logic [7:0] e0, input logic [7:0] e1,
                           input logic [7:0] e2, input logic [7:0] e3);
    check({tag, "_b0"}, b0, e0);
    check({tag, "_b1"}, b1, e1);
    check({tag, "_b2"}, b2, e2);
    check({tag, "_b3"}, b3, e3);
  endtask

  task automatic pulse_req();
    report_req = 1'b1;
    @(negedge clk);
    report_req = 1'b0;
  endtask

  task automatic wait_count(input logic [7:0] exp, input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (pkt_count === exp) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [7:0] b0, b1, b2, b3;
    logic [7:0] c0, c1, c2, c3;
    int se, se2, ref_c, bh0, tl0;
    bit ok;

    // Boot packet
    emotion = 8'h3C;
    status  = 8'h95;
    rst_n   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_pkt_count", pkt_count, 8'd0);
    bh0   = busy_hi;
    ref_c = cyc;
    rst_n = 1'b1;
    wait_start(50, se);
    check("boot_start_edge", se, ref_c + 3);
    recv_pkt(b0, b1, b2, b3);
    check_pkt("boot", b0, b1, b2, b3, 8'hA5, 8'h3C, 8'h95, 8'h0C);
    repeat (10) @(negedge clk);
    check("boot_busy_len", busy_hi - bh0, 164);
    check("boot_busy_low", busy, 1'b0);
    check("boot_pkt_count", pkt_count, 8'd1);

    // Change detect
    repeat (20) @(negedge clk);
    ref_c   = cyc;
    emotion = 8'h41;
    wait_start(20, se);
    check("chg_start_edge", se, ref_c + 3);
    recv_pkt(b0, b1, b2, b3);
    check_pkt("chg", b0, b1, b2, b3, 8'hA5, 8'h41, 8'h95, 8'h71);
    repeat (10) @(negedge clk);
    bh0 = busy_hi;
    repeat (1000) @(negedge clk);
    check("chg_no_repeat_busy", busy_hi - bh0, 0);
    check("chg_pkt_count", pkt_count, 8'd2);

    // Glitch rejection
    tl0    = tx_low;
    bh0    = busy_hi;
    status = 8'h00;
    @(negedge clk);
    status = 8'h95;
    repeat (50) @(negedge clk);
    check("glitch_tx_low", tx_low - tl0, 0);
    check("glitch_busy", busy_hi - bh0, 0);
    check("glitch_pkt_count", pkt_count, 8'd2);

    // Input changes during a packet
    ref_c   = cyc;
    emotion = 8'h55;
    wait_start(20, se);
    check("mid_start_edge", se, ref_c + 3);
    recv_byte(1'b1, b0);
    emotion = 8'h10;
    recv_byte(1'b0, b1);
    emotion = 8'h20;
    recv_byte(1'b0, b2);
    emotion = 8'h30;
    recv_byte(1'b0, b3);
    check_pkt("mid_first", b0, b1, b2, b3, 8'hA5, 8'h55, 8'h95, 8'h65);
    wait_start(30, se2);
    check("mid_follow_spacing", se2 - se, 41 * CPB);
    recv_pkt(b0, b1, b2, b3);
    check_pkt("mid_follow", b0, b1, b2, b3, 8'hA5, 8'h30, 8'h95, 8'h00);
    repeat (300) @(negedge clk);
    check("mid_pkt_count", pkt_count, 8'd4);
    check("mid_idle", busy, 1'b0);

    // Forced report with coalesced requests
    ref_c = cyc;
    pulse_req();
    wait_start(20, se);
    check("req_start_edge", se, ref_c + 2);
    fork
      recv_pkt(b0, b1, b2, b3);
      begin
        repeat (30) @(negedge clk);
        pulse_req();
        repeat (40) @(negedge clk);
        pulse_req();
        repeat (40) @(negedge clk);
        pulse_req();
      end
    join
    check_pkt("req_first", b0, b1, b2, b3, 8'hA5, 8'h30, 8'h95, 8'h00);
    wait_start(30, se2);
    check("req_repeat_spacing", se2 - se, 41 * CPB);
    recv_pkt(c0, c1, c2, c3);
    check_pkt("req_repeat", c0, c1, c2, c3, 8'hA5, 8'h30, 8'h95, 8'h00);
    repeat (300) @(negedge clk);
    check("req_pkt_count", pkt_count, 8'd6);
    check("req_idle", busy, 1'b0);

    // Reset during byte 2
    pulse_req();
    wait_start(20, se);
    recv_byte(1'b1, b0);
    recv_byte(1'b0, b1);
    repeat (10) @(negedge clk);
    check("mrst_busy_before", busy, 1'b1);
    check("mrst_count_before", pkt_count, 8'd6);
    rst_n = 1'b0;
    #1;
    check("mrst_tx", tx, 1'b1);
    check("mrst_busy", busy, 1'b0);
    check("mrst_pkt_count", pkt_count, 8'd0);
    repeat (2) @(negedge clk);
    ref_c = cyc;
    rst_n = 1'b1;
    wait_start(50, se);
    check("mrst_boot_edge", se, ref_c + 3);
    recv_pkt(b0, b1, b2, b3);
    check_pkt("mrst_boot", b0, b1, b2, b3, 8'hA5, 8'h30, 8'h95, 8'h00);
    repeat (10) @(negedge clk);
    check("mrst_boot_count", pkt_count, 8'd1);

    // Counter wrap over 256 packets since reset
    for (int i = 1; i < 255; i++) begin
      pulse_req();
      wait_count(8'(i + 1), 400, ok);
      if (!ok) begin
        check("wrap_progress", pkt_count, 8'(i + 1));
        break;
      end
    end
    check("wrap_at_255", pkt_count, 8'd255);
    pulse_req();
    wait_count(8'd0, 400, ok);
    check("wrap_to_0", pkt_count, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
